// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode values and instruction word field layout.
// Used by the request encoder/queue and by the downstream decoder.
package isa_pkg;

    localparam logic [7:0] OP_MOV   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_LOADI = 8'h08;

    localparam int WORD_W     = 32;
    localparam int FIELD_W    = 8;
    localparam int REG_W      = 3;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_LSB   = 16;
    localparam int SRC2_LSB   = 8;
    localparam int SRC1_LSB   = 0;

    typedef struct packed {
        logic [7:0]       opcode;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic [7:0]       imm;
    } req_fields_t;

    // Register addresses occupy a full byte lane in the encoded word.
    function automatic logic [FIELD_W-1:0] zext_reg(input logic [REG_W-1:0] r);
        return {{(FIELD_W-REG_W){1'b0}}, r};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational instruction encoder: packs request fields into a 32-bit word
// and flags whether the opcode is one the decoder understands.
module instr_encode
    import isa_pkg::*;
(
    input  logic [$bits(req_fields_t)-1:0] req,
    output logic [WORD_W-1:0]              word,
    output logic                           legal
);

    req_fields_t fields;

    assign fields = req_fields_t'(req);

    // Illegal opcodes produce an all-zero word; the queue never stores them anyway.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fields.opcode)
            OP_MOV: begin
                legal                         = 1'b1;
                word[OPCODE_LSB +: FIELD_W]   = fields.opcode;
                word[DEST_LSB +: FIELD_W]     = zext_reg(fields.dest);
                word[SRC1_LSB +: FIELD_W]     = zext_reg(fields.src1);
            end
            OP_LOADI: begin
                legal                         = 1'b1;
                word[OPCODE_LSB +: FIELD_W]   = fields.opcode;
                word[DEST_LSB +: FIELD_W]     = zext_reg(fields.dest);
                word[SRC1_LSB +: FIELD_W]     = fields.imm;
            end
            OP_ADD, OP_AND, OP_OR, OP_SUB: begin
                legal                         = 1'b1;
                word[OPCODE_LSB +: FIELD_W]   = fields.opcode;
                word[DEST_LSB +: FIELD_W]     = zext_reg(fields.dest);
                word[SRC2_LSB +: FIELD_W]     = zext_reg(fields.src2);
                word[SRC1_LSB +: FIELD_W]     = zext_reg(fields.src1);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_queue.sv
// Instruction request encoder with a small FIFO of encoded words feeding the
// decoder. Illegal opcodes are consumed, dropped and reported with a pulse.
module instr_encoder_queue
    import isa_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_opcode,
    input  logic [2:0]               req_dest,
    input  logic [2:0]               req_src1,
    input  logic [2:0]               req_src2,
    input  logic [7:0]               req_imm,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instruction,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              init_done;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] enc_word;
    logic              enc_legal;
    req_fields_t       req_fields;

    assign req_fields = '{opcode: req_opcode, dest: req_dest, src1: req_src1,
                          src2: req_src2, imm: req_imm};

    instr_encode u_encode (
        .req   (req_fields),
        .word  (enc_word),
        .legal (enc_legal)
    );

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // init_done holds req_ready low until the first clock edge after reset.
    assign req_ready   = init_done && !full && !flush;
    assign accept      = req_valid && req_ready;
    assign push        = accept && enc_legal;
    assign pop         = instr_valid && instr_ready && !flush;
    assign instr_valid = !empty;
    assign instruction = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // Flush takes priority over any pop; issued only counts real consumption.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            issued      <= '0;
            err_illegal <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            init_done   <= 1'b1;
            err_illegal <= accept && !enc_legal;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    issued <= issued + 8'd1;
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_queue.sv
// Directed bench for instr_encoder_queue: encoding table plus queue corner
// sequences (full, simultaneous push/pop, flush, async reset, issued wrap).
module tb_instr_encoder_queue;
    import isa_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        RESET;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opcode;
    logic [2:0]  req_dest;
    logic [2:0]  req_src1;
    logic [2:0]  req_src2;
    logic [7:0]  req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        err_illegal;
    logic [2:0]  count;
    logic [7:0]  issued;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_issued;

    typedef struct {
        logic [7:0]  opcode;
        logic [2:0]  dest;
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic [7:0]  imm;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    vec_t vecs[10];

    instr_encoder_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_dest    (req_dest),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .err_illegal (err_illegal),
        .count       (count),
        .issued      (issued)
    );

    always #5 clk = ~clk;

    // Drive all producer/consumer inputs in one go, always between clock edges.
    task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [2:0] d,
                                 input logic [2:0] s1, input logic [2:0] s2,
                                 input logic [7:0] imm, input logic rdy, input logic fl);
        req_valid   = v;
        req_opcode  = op;
        req_dest    = d;
        req_src1    = s1;
        req_src2    = s2;
        req_imm     = imm;
        instr_ready = rdy;
        flush       = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] addWord(input int d, input int s1);
        return {8'h01, 8'(d), 8'h00, 8'(s1)};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{OP_ADD,   3'd1, 3'd4, 3'd2, 8'h00, 32'h01010204, 1'b1};
        vecs[1] = '{OP_LOADI, 3'd3, 3'd6, 3'd5, 8'hFF, 32'h080300FF, 1'b1};
        vecs[2] = '{OP_MOV,   3'd7, 3'd5, 3'd3, 8'hAA, 32'h00070005, 1'b1};
        vecs[3] = '{OP_AND,   3'd2, 3'd3, 3'd6, 8'h11, 32'h02020603, 1'b1};
        vecs[4] = '{OP_OR,    3'd0, 3'd7, 3'd7, 8'h00, 32'h03000707, 1'b1};
        vecs[5] = '{OP_SUB,   3'd5, 3'd1, 3'd4, 8'h5A, 32'h04050401, 1'b1};
        vecs[6] = '{8'h07,    3'd1, 3'd1, 3'd1, 8'h00, 32'h00000000, 1'b0};
        vecs[7] = '{8'h05,    3'd2, 3'd3, 3'd4, 8'h00, 32'h00000000, 1'b0};
        vecs[8] = '{8'hFF,    3'd7, 3'd7, 3'd7, 8'hFF, 32'h00000000, 1'b0};
        vecs[9] = '{8'h09,    3'd4, 3'd2, 3'd1, 8'h33, 32'h00000000, 1'b0};

        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        RESET = 1'b0;
        #1;
        checkOutput("reset count", 32'(count), 0);
        checkOutput("reset instr_valid", 32'(instr_valid), 0);
        checkOutput("reset instruction", instruction, 0);
        checkOutput("reset err_illegal", 32'(err_illegal), 0);
        checkOutput("reset issued", 32'(issued), 0);
        checkOutput("reset req_ready", 32'(req_ready), 0);
        #1 RESET = 1'b1;
        #1 checkOutput("req_ready before first edge", 32'(req_ready), 0);
        @(negedge clk);
        checkOutput("req_ready after first edge", 32'(req_ready), 1);
        exp_issued = 8'd0;

        // Encoding table: push one request, inspect, then pop (ignored when empty).
        foreach (vecs[i]) begin
            applyStimulus(1, vecs[i].opcode, vecs[i].dest, vecs[i].src1, vecs[i].src2,
                          vecs[i].imm, 0, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].legal));
            checkOutput($sformatf("vec%0d instruction", i), instruction, vecs[i].word);
            checkOutput($sformatf("vec%0d err_illegal", i), 32'(err_illegal), 32'(!vecs[i].legal));
            checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].legal));
            applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
            @(negedge clk);
            if (vecs[i].legal) exp_issued = exp_issued + 8'd1;
            checkOutput($sformatf("vec%0d count after pop", i), 32'(count), 0);
            checkOutput($sformatf("vec%0d err_illegal clear", i), 32'(err_illegal), 0);
            checkOutput($sformatf("vec%0d issued", i), 32'(issued), 32'(exp_issued));
        end

        // Fill to DEPTH; a push offered while full must not land even with a pop.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1, OP_ADD, 3'(i), 3'(i), 0, 8'h00, 0, 0);
            @(negedge clk);
        end
        checkOutput("full count", 32'(count), 4);
        checkOutput("full req_ready", 32'(req_ready), 0);
        checkOutput("full head", instruction, addWord(1, 1));
        applyStimulus(1, OP_ADD, 3'd5, 3'd5, 0, 8'h00, 1, 0);
        @(negedge clk);
        exp_issued = exp_issued + 8'd1;
        checkOutput("full pop count", 32'(count), 3);
        checkOutput("full pop head", instruction, addWord(2, 2));
        checkOutput("full pop issued", 32'(issued), 32'(exp_issued));
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
        @(negedge clk);
        exp_issued = exp_issued + 8'd1;
        checkOutput("pop to two count", 32'(count), 2);
        applyStimulus(1, OP_ADD, 3'd6, 3'd6, 0, 8'h00, 1, 0);
        @(negedge clk);
        exp_issued = exp_issued + 8'd1;
        checkOutput("push+pop count", 32'(count), 2);
        checkOutput("push+pop issued", 32'(issued), 32'(exp_issued));
        checkOutput("push+pop head", instruction, addWord(4, 4));
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
        @(negedge clk);
        exp_issued = exp_issued + 8'd1;
        checkOutput("drain head", instruction, addWord(6, 6));
        @(negedge clk);
        exp_issued = exp_issued + 8'd1;
        checkOutput("drain count", 32'(count), 0);
        checkOutput("drain instr_valid", 32'(instr_valid), 0);
        checkOutput("drain issued", 32'(issued), 32'(exp_issued));

        // Flush beats a concurrent pop and push, and restarts both pointers.
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1, OP_ADD, 3'(i), 3'(i), 0, 8'h00, 0, 0);
            @(negedge clk);
        end
        applyStimulus(1, OP_ADD, 3'd7, 3'd7, 0, 8'h00, 1, 1);
        #1 checkOutput("flush req_ready", 32'(req_ready), 0);
        @(negedge clk);
        checkOutput("flush count", 32'(count), 0);
        checkOutput("flush instr_valid", 32'(instr_valid), 0);
        checkOutput("flush issued", 32'(issued), 32'(exp_issued));
        applyStimulus(1, OP_MOV, 3'd2, 3'd3, 0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("post-flush head", instruction, 32'h00020003);
        checkOutput("post-flush count", 32'(count), 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
        @(negedge clk);
        exp_issued = exp_issued + 8'd1;
        checkOutput("post-flush issued", 32'(issued), 32'(exp_issued));

        // Asynchronous reset in the middle of a cycle with three entries queued.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, OP_ADD, 3'(i), 3'(i), 0, 8'h00, 0, 0);
            @(negedge clk);
        end
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("pre-reset count", 32'(count), 3);
        #2 RESET = 1'b0;
        #1;
        checkOutput("midreset count", 32'(count), 0);
        checkOutput("midreset instr_valid", 32'(instr_valid), 0);
        checkOutput("midreset issued", 32'(issued), 0);
        checkOutput("midreset instruction", instruction, 0);
        checkOutput("midreset req_ready", 32'(req_ready), 0);
        @(negedge clk);
        #1 RESET = 1'b1;
        @(negedge clk);
        checkOutput("after reset req_ready", 32'(req_ready), 1);
        checkOutput("after reset instr_valid", 32'(instr_valid), 0);

        // 260 pops from a freshly reset counter wrap issued to 4.
        applyStimulus(1, OP_ADD, 3'd1, 3'd1, 0, 8'h00, 0, 0);
        @(negedge clk);
        applyStimulus(1, OP_ADD, 3'd1, 3'd1, 0, 8'h00, 1, 0);
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
        end
        checkOutput("wrap issued", 32'(issued), 4);
        checkOutput("wrap count", 32'(count), 1);
        checkOutput("wrap head", instruction, addWord(1, 1));
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
        @(negedge clk);
        checkOutput("wrap final issued", 32'(issued), 5);
        checkOutput("wrap final count", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
